// File: rtl/sw_debounce_if.sv
// ----------------------------------------------------------------------------
// sw_debounce_if
// Bundles the raw switch levels and the conditioned switch outputs that pass
// between the board switches and the debouncer.
//
// Signals:
//   sw        raw, asynchronous switch levels (driven by the board/master side)
//   sw_clean  debounced switch levels
//   sw_rise   per-bit one-cycle pulse on a clean 0->1 change
//   sw_fall   per-bit one-cycle pulse on a clean 1->0 change
//   changed   one-cycle pulse when any clean bit changed
//
// Modports:
//   master  board side: drives sw, observes the conditioned outputs
//   slave   debouncer side: reads sw, drives the conditioned outputs
// ----------------------------------------------------------------------------
interface sw_debounce_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sw;
  logic [WIDTH-1:0] sw_clean;
  logic [WIDTH-1:0] sw_rise;
  logic [WIDTH-1:0] sw_fall;
  logic             changed;

  modport master (
    output sw,
    input  sw_clean,
    input  sw_rise,
    input  sw_fall,
    input  changed
  );

  modport slave (
    input  sw,
    output sw_clean,
    output sw_rise,
    output sw_fall,
    output changed
  );
endinterface

// File: rtl/sw_debounce.sv
// ----------------------------------------------------------------------------
// sw_debounce
// Synchronises each raw slide-switch bit into the clk domain and debounces it
// independently. A clean bit only flips after its synchronised level has
// differed from the clean value for STABLE_CYCLES consecutive cycles; any
// bounce back earlier discards the progress. Rise/fall strobes and the
// aggregate 'changed' pulse are registered and aligned with the clean update.
//
// Parameters:
//   WIDTH          number of switch bits conditioned
//   STABLE_CYCLES  qualification length in clock cycles (>= 1)
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (deassertion synchronised upstream)
//   bus    sw_debounce_if slave modport: sw in; sw_clean, sw_rise, sw_fall,
//          changed out (all outputs registered, no path from sw)
// ----------------------------------------------------------------------------
module sw_debounce #(
  parameter int WIDTH         = 8,
  parameter int STABLE_CYCLES = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  sw_debounce_if.slave  bus
);

  // Counter holds 0 .. STABLE_CYCLES-1, so this width never lets it wrap.
  localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]         s1_r;
  logic [WIDTH-1:0]         s2_r;
  logic [WIDTH-1:0][CW-1:0] cnt_r;
  logic [WIDTH-1:0]         clean_r;
  logic [WIDTH-1:0]         rise_r;
  logic [WIDTH-1:0]         fall_r;
  logic                     changed_r;

  logic [WIDTH-1:0][CW-1:0] cnt_next_s;
  logic [WIDTH-1:0]         clean_next_s;
  logic [WIDTH-1:0]         rise_next_s;
  logic [WIDTH-1:0]         fall_next_s;

  // Per-bit qualification: reset progress on agreement, flip on the last count.
  always_comb begin
    cnt_next_s   = cnt_r;
    clean_next_s = clean_r;
    rise_next_s  = '0;
    fall_next_s  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_r[i] == clean_r[i]) begin
        cnt_next_s[i] = '0;
      end else if (cnt_r[i] == LAST_CNT) begin
        clean_next_s[i] = s2_r[i];
        cnt_next_s[i]   = '0;
        if (s2_r[i]) begin
          rise_next_s[i] = 1'b1;
        end else begin
          fall_next_s[i] = 1'b1;
        end
      end else begin
        cnt_next_s[i] = cnt_r[i] + CW'(1);
      end
    end
  end

  // Two-flop synchroniser plus registered debounce state and strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_r      <= '0;
      s2_r      <= '0;
      cnt_r     <= '0;
      clean_r   <= '0;
      rise_r    <= '0;
      fall_r    <= '0;
      changed_r <= 1'b0;
    end else begin
      s1_r      <= bus.sw;
      s2_r      <= s1_r;
      cnt_r     <= cnt_next_s;
      clean_r   <= clean_next_s;
      rise_r    <= rise_next_s;
      fall_r    <= fall_next_s;
      // Built from the next-state strobes so it lands in the same cycle.
      changed_r <= |(rise_next_s | fall_next_s);
    end
  end

  assign bus.sw_clean = clean_r;
  assign bus.sw_rise  = rise_r;
  assign bus.sw_fall  = fall_r;
  assign bus.changed  = changed_r;

endmodule

// File: tb/tb_sw_debounce.sv
// ----------------------------------------------------------------------------
// tb_sw_debounce
// Directed bench for sw_debounce with WIDTH=8, STABLE_CYCLES=4. A level held
// from edge E0 onward reaches sw_clean (with its strobe) at edge E0+5.
// Per-edge vectors {sw, expected clean/rise/fall/changed} are built first and
// replayed; reset behaviour is exercised by hand-written sequences.
// ----------------------------------------------------------------------------
module tb_sw_debounce;

  logic clk;
  logic rst_n;

  int tests;
  int fails;

  typedef struct {
    logic [7:0] sw;
    logic [7:0] clean;
    logic [7:0] rise;
    logic [7:0] fall;
    logic       chg;
  } vec_t;

  vec_t vecs[$];

  sw_debounce_if #(.WIDTH(8)) bus ();

  sw_debounce #(
    .WIDTH         (8),
    .STABLE_CYCLES (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic [7:0] c, input logic [7:0] r,
                           input logic [7:0] f, input logic ch);
    check({tag, ".clean"},   bus.sw_clean,        c);
    check({tag, ".rise"},    bus.sw_rise,         r);
    check({tag, ".fall"},    bus.sw_fall,         f);
    check({tag, ".changed"}, {7'd0, bus.changed}, {7'd0, ch});
  endtask

  task automatic push(input logic [7:0] s, input logic [7:0] c, input logic [7:0] r,
                      input logic [7:0] f, input logic ch);
    vec_t v;
    v.sw = s; v.clean = c; v.rise = r; v.fall = f; v.chg = ch;
    vecs.push_back(v);
  endtask

  // n quiet edges with sw held and sw_clean expected at c.
  task automatic hold(input logic [7:0] s, input int n, input logic [7:0] c);
    for (int k = 0; k < n; k++) push(s, c, 8'h00, 8'h00, 1'b0);
  endtask

  initial begin
    tests = 0;
    fails = 0;

    // ---------------- vector table (starts from clean = 8'hFF) -------------
    // Back to all-zero: 5 quiet edges, then every bit falls together.
    hold(8'h00, 5, 8'hFF);
    push(8'h00, 8'h00, 8'h00, 8'hFF, 1'b1);
    hold(8'h00, 1, 8'h00);
    // Clean step on bit 2.
    hold(8'h04, 5, 8'h00);
    push(8'h04, 8'h04, 8'h04, 8'h00, 1'b1);
    hold(8'h04, 1, 8'h04);
    // Bounce on bit 0, then settle high: only the final settle qualifies.
    push(8'h05, 8'h04, 8'h00, 8'h00, 1'b0);
    push(8'h04, 8'h04, 8'h00, 8'h00, 1'b0);
    push(8'h05, 8'h04, 8'h00, 8'h00, 1'b0);
    push(8'h04, 8'h04, 8'h00, 8'h00, 1'b0);
    hold(8'h05, 5, 8'h04);
    push(8'h05, 8'h05, 8'h01, 8'h00, 1'b1);
    hold(8'h05, 1, 8'h05);
    // 3-cycle pulse on bit 7: rejected.
    hold(8'h85, 3, 8'h05);
    hold(8'h05, 8, 8'h05);
    // 4-cycle pulse on bit 7: one rise, one fall 4 cycles later.
    hold(8'h85, 4, 8'h05);
    hold(8'h05, 1, 8'h05);
    push(8'h05, 8'h85, 8'h80, 8'h00, 1'b1);
    hold(8'h05, 3, 8'h85);
    push(8'h05, 8'h05, 8'h00, 8'h80, 1'b1);
    hold(8'h05, 1, 8'h05);
    // Move to 8'h0F, then swap every bit at once.
    hold(8'h0F, 5, 8'h05);
    push(8'h0F, 8'h0F, 8'h0A, 8'h00, 1'b1);
    hold(8'h0F, 1, 8'h0F);
    hold(8'hF0, 5, 8'h0F);
    push(8'hF0, 8'hF0, 8'hF0, 8'h0F, 1'b1);
    hold(8'hF0, 1, 8'hF0);
    // Return to zero ahead of the reset mid-count sequence.
    hold(8'h00, 5, 8'hF0);
    push(8'h00, 8'h00, 8'h00, 8'hF0, 1'b1);
    hold(8'h00, 1, 8'h00);

    // ---------------- reset values, then release with sw held high --------
    rst_n  = 1'b0;
    bus.sw = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all("reset_hold", 8'h00, 8'h00, 8'h00, 1'b0);
    rst_n = 1'b1;
    // First post-release edge is E0; the flip is expected on edge E0+5.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("release_e%0d", k),
                (k >= 5) ? 8'hFF : 8'h00,
                (k == 5) ? 8'hFF : 8'h00,
                8'h00,
                (k == 5));
    end

    // ---------------- replay vector table ---------------------------------
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      bus.sw = vecs[i].sw;
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].clean, vecs[i].rise,
                vecs[i].fall, vecs[i].chg);
    end

    // ---------------- reset in the middle of a qualification --------------
    @(negedge clk);
    bus.sw = 8'h20;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all("midreset_assert", 8'h00, 8'h00, 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      #1;
      check_all($sformatf("midreset_e%0d", k),
                (k >= 5) ? 8'h20 : 8'h00,
                (k == 5) ? 8'h20 : 8'h00,
                8'h00,
                (k == 5));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Input conditioning stage between the board slide switches and the combinational adder datapath (majority-light, half adder, 2-bit ripple adder). Each raw switch is synchronised into the system clock domain and debounced independently. The block then presents a stable, glitch-free operand vector plus one-cycle edge strobes, so the downstream adders and LEDs never see metastable or bouncing inputs.

## Interface
- `WIDTH`, default 8: number of switch bits conditioned; sized to cover all operand bits the adder stage consumes.
- `STABLE_CYCLES`, default 100000: consecutive clock cycles a synchronised bit must differ from its clean value before the clean value flips (1 ms at 100 MHz). Legal range ≥ 1.
- `clk`  input  1  system clock, all state updates on rising edge.
- `rst_n`  input  1  asynchronous active-low reset.
- `sw`  input  WIDTH  raw, asynchronous switch levels.
- `sw_clean`  output  WIDTH  debounced switch levels, registered; drives the adder operand inputs.
- `sw_rise`  output  WIDTH  per-bit one-cycle pulse, asserted in the cycle `sw_clean[i]` goes 0→1.
- `sw_fall`  output  WIDTH  per-bit one-cycle pulse, asserted in the cycle `sw_clean[i]` goes 1→0.
- `changed`  output  1  one-cycle pulse, high in any cycle where at least one `sw_clean` bit changed.

## Operation
- Synchroniser: two flop stages per bit, `s1 <= sw`, `s2 <= s1`. Only `s2` is used downstream.
- Per-bit counter `cnt[i]`, width `$clog2(STABLE_CYCLES+1)`, unsigned, never wraps.
- Per-bit rule, evaluated every edge:
  - if `s2[i] == sw_clean[i]`: `cnt[i] <= 0`. This means idle, or a bounce back before qualification, which discards all progress.
  - else if `cnt[i] == STABLE_CYCLES-1`: `sw_clean[i] <= s2[i]`, `cnt[i] <= 0`, pulse the matching `sw_rise[i]` or `sw_fall[i]`.
  - else: `cnt[i] <= cnt[i] + 1`.
- Bits are fully independent. Any number of bits may qualify in the same cycle, and all of their strobes assert together.
- `changed` is the registered OR of `sw_rise | sw_fall` for the same cycle. It is aligned with those strobes, not delayed behind them.
- Strobes are registered. They are low in every cycle where the corresponding bit did not flip.
- Reset (async assert, any time including mid-count):
  - `s1`, `s2`, `cnt`, `sw_clean`, `sw_rise`, `sw_fall` and `changed` all clear to 0 immediately.
  - No strobes are generated by reset itself.
  - After release, a switch held high is treated as a new 0→1 change and re-qualifies in full.
- Deassertion of `rst_n` is synchronised externally by the board-level reset logic; this block does not re-synchronise it.

## Timing
- Latency: raw level first sampled at edge E0 and held stable. `s2` updates at E0+1. `sw_clean` and its strobe update at edge E0+STABLE_CYCLES+1.
- With `STABLE_CYCLES=1`, the clean output follows the raw switch with exactly two cycles of latency (pure synchroniser).
- A pulse on `sw` that is shorter than STABLE_CYCLES cycles after synchronisation never reaches `sw_clean`. A pulse of exactly STABLE_CYCLES cycles is passed.
- Strobe width is exactly 1 cycle. The minimum spacing between two strobes on the same bit is STABLE_CYCLES cycles.
- No combinational path exists from `sw` to any output.

## Test plan
(Simulation uses `STABLE_CYCLES=4`, `WIDTH=8`.)
- Reset values: hold `rst_n=0` with `sw=8'hFF` → all outputs 0. Release reset → `sw_clean` becomes 8'hFF and `sw_rise` becomes 8'hFF for one cycle at edge 5 after release, with `changed=1` in that same cycle.
- Clean step: `sw[2]` goes 0→1 and is held → `sw_clean[2]=1` exactly 5 edges later, `sw_rise=8'h04` for one cycle, all other bits unchanged.
- Bounce rejection: `sw[0]` toggles 1,0,1,0 every cycle for 3 cycles, then settles at 1 → `sw_clean[0]` rises only 5 edges after the final settle, with exactly one `sw_rise[0]` pulse.
- Short pulse: `sw[7]` high for 3 cycles → no change on `sw_clean[7]` and no strobes. Repeat with a 4-cycle pulse → one rise, then one fall 4 cycles later.
- Simultaneous: `sw` goes 8'h0F→8'hF0 in one step → in a single cycle `sw_rise=8'hF0`, `sw_fall=8'h0F`, `changed=1`, and `sw_clean=8'hF0`.
- Reset mid-count: `sw[5]` goes 0→1, `rst_n` is pulsed low after 2 cycles → counter is cleared. After release, `sw_clean[5]` rises 5 edges after the first post-reset edge, not earlier.
